// File: rtl/preg_ready_table_pkg.sv
// Shared constants and types for the physical-register ready scoreboard.
package preg_ready_table_pkg;

  localparam int unsigned NUM_PR  = 128;
  localparam int unsigned PR_W    = 7;
  localparam int unsigned NUM_CDB = 6;
  localparam int unsigned CNT_W   = 8;

  typedef logic [NUM_PR-1:0] pr_vec_t;
  typedef logic [PR_W-1:0]   pr_tag_t;

  // Number of clear bits, i.e. physical registers still waiting on a producer.
  function automatic logic [CNT_W-1:0] count_not_ready(pr_vec_t v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_PR; i++) begin
      cnt = cnt + {{(CNT_W-1){1'b0}}, ~v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/preg_ready_table_pr_decode.sv
// Qualified tag to one-hot physical-register vector.
module preg_ready_table_pr_decode
  import preg_ready_table_pkg::*;
(
  input  logic    valid_i,
  input  pr_tag_t tag_i,
  output pr_vec_t onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (valid_i) begin
      onehot_o[tag_i] = 1'b1;
    end
  end

endmodule

// File: rtl/preg_ready_table.sv
// Physical-register ready table: CDB wakeups set, dispatch allocations clear,
// dispatch source lookups see same-cycle wakeups and intra-group dependencies.
module preg_ready_table
  import preg_ready_table_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_CDB-1:0]  cdb_broadcast,
  input  logic [PR_W-1:0]     cdb_pr_tag0,
  input  logic [PR_W-1:0]     cdb_pr_tag1,
  input  logic [PR_W-1:0]     cdb_pr_tag2,
  input  logic [PR_W-1:0]     cdb_pr_tag3,
  input  logic [PR_W-1:0]     cdb_pr_tag4,
  input  logic [PR_W-1:0]     cdb_pr_tag5,
  input  logic                disp_valid0,
  input  logic                disp_valid1,
  input  logic [PR_W-1:0]     disp_dest_pr0,
  input  logic [PR_W-1:0]     disp_dest_pr1,
  input  logic [PR_W-1:0]     disp_src_a_pr0,
  input  logic [PR_W-1:0]     disp_src_b_pr0,
  input  logic [PR_W-1:0]     disp_src_a_pr1,
  input  logic [PR_W-1:0]     disp_src_b_pr1,
  input  logic                recover,
  output logic                src_a_rdy0,
  output logic                src_b_rdy0,
  output logic                src_a_rdy1,
  output logic                src_b_rdy1,
  output logic [CNT_W-1:0]    busy_count,
  output logic                dup_wakeup_err
);

  pr_tag_t cdb_tag [NUM_CDB];
  pr_vec_t lane_hot [NUM_CDB];
  pr_vec_t dest_hot [2];
  pr_vec_t set_vec, clr_vec;

  pr_vec_t          ready_q, ready_d;
  logic [CNT_W-1:0] busy_count_q, busy_count_d;
  logic             dup_err_q, dup_err_d;

  assign cdb_tag[0] = cdb_pr_tag0;
  assign cdb_tag[1] = cdb_pr_tag1;
  assign cdb_tag[2] = cdb_pr_tag2;
  assign cdb_tag[3] = cdb_pr_tag3;
  assign cdb_tag[4] = cdb_pr_tag4;
  assign cdb_tag[5] = cdb_pr_tag5;

  for (genvar i = 0; i < NUM_CDB; i++) begin : g_cdb_dec
    preg_ready_table_pr_decode u_dec (
      .valid_i  (cdb_broadcast[i]),
      .tag_i    (cdb_tag[i]),
      .onehot_o (lane_hot[i])
    );
  end

  preg_ready_table_pr_decode u_dest_dec0 (
    .valid_i  (disp_valid0),
    .tag_i    (disp_dest_pr0),
    .onehot_o (dest_hot[0])
  );

  preg_ready_table_pr_decode u_dest_dec1 (
    .valid_i  (disp_valid1),
    .tag_i    (disp_dest_pr1),
    .onehot_o (dest_hot[1])
  );

  always_comb begin
    set_vec = '0;
    for (int i = 0; i < NUM_CDB; i++) begin
      set_vec = set_vec | lane_hot[i];
    end
    clr_vec = dest_hot[0] | dest_hot[1];
  end

  // Clear after set: a fresh allocation outranks a wakeup of the old mapping.
  always_comb begin
    ready_d   = recover ? '1 : ((ready_q | set_vec) & ~clr_vec);
    dup_err_d = dup_err_q | (~recover & (|(set_vec & ready_q & ~clr_vec)));
    busy_count_d = count_not_ready(ready_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q      <= '1;
      busy_count_q <= '0;
      dup_err_q    <= 1'b0;
    end else begin
      ready_q      <= ready_d;
      busy_count_q <= busy_count_d;
      dup_err_q    <= dup_err_d;
    end
  end

  // Slot1 cannot consume slot0's result in the same group, so it must wait.
  always_comb begin
    src_a_rdy0 = ready_q[disp_src_a_pr0] | set_vec[disp_src_a_pr0];
    src_b_rdy0 = ready_q[disp_src_b_pr0] | set_vec[disp_src_b_pr0];
    src_a_rdy1 = (ready_q[disp_src_a_pr1] | set_vec[disp_src_a_pr1]) &
                 ~(disp_valid0 && (disp_src_a_pr1 == disp_dest_pr0));
    src_b_rdy1 = (ready_q[disp_src_b_pr1] | set_vec[disp_src_b_pr1]) &
                 ~(disp_valid0 && (disp_src_b_pr1 == disp_dest_pr0));
  end

  assign busy_count     = busy_count_q;
  assign dup_wakeup_err = dup_err_q;

endmodule

// File: tb/tb_preg_ready_table.sv
// Scoreboard bench for preg_ready_table: directed scenarios then random traffic.
module tb_preg_ready_table;

  localparam int NPR = 128;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] cdb_broadcast;
  logic [6:0] cdb_tag [6];
  logic       disp_valid0, disp_valid1;
  logic [6:0] disp_dest_pr0, disp_dest_pr1;
  logic [6:0] sa0, sb0, sa1, sb1;
  logic       recover;
  logic       src_a_rdy0, src_b_rdy0, src_a_rdy1, src_b_rdy1;
  logic [7:0] busy_count;
  logic       dup_wakeup_err;

  typedef struct packed {
    logic       a0, b0, a1, b1;
    logic [7:0] busy;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  bit m_ready [NPR];
  bit m_err;

  always #5 clock = ~clock;

  preg_ready_table dut (
    .clock          (clock),
    .reset          (reset),
    .cdb_broadcast  (cdb_broadcast),
    .cdb_pr_tag0    (cdb_tag[0]),
    .cdb_pr_tag1    (cdb_tag[1]),
    .cdb_pr_tag2    (cdb_tag[2]),
    .cdb_pr_tag3    (cdb_tag[3]),
    .cdb_pr_tag4    (cdb_tag[4]),
    .cdb_pr_tag5    (cdb_tag[5]),
    .disp_valid0    (disp_valid0),
    .disp_valid1    (disp_valid1),
    .disp_dest_pr0  (disp_dest_pr0),
    .disp_dest_pr1  (disp_dest_pr1),
    .disp_src_a_pr0 (sa0),
    .disp_src_b_pr0 (sb0),
    .disp_src_a_pr1 (sa1),
    .disp_src_b_pr1 (sb1),
    .recover        (recover),
    .src_a_rdy0     (src_a_rdy0),
    .src_b_rdy0     (src_b_rdy0),
    .src_a_rdy1     (src_a_rdy1),
    .src_b_rdy1     (src_b_rdy1),
    .busy_count     (busy_count),
    .dup_wakeup_err (dup_wakeup_err)
  );

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, written directly from the scoreboard rules.
  function automatic bit broadcast_hits(input int p);
    for (int i = 0; i < 6; i++) if (cdb_broadcast[i] && cdb_tag[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit allocated(input int p);
    return (disp_valid0 && disp_dest_pr0 == p) || (disp_valid1 && disp_dest_pr1 == p);
  endfunction

  function automatic bit src_ready(input int p, input bit slot1);
    bit r;
    r = m_ready[p] || broadcast_hits(p);
    if (slot1 && disp_valid0 && disp_dest_pr0 == p) r = 1'b0;
    return r;
  endfunction

  function automatic int waiting_regs();
    int n = 0;
    for (int p = 0; p < NPR; p++) if (!m_ready[p]) n++;
    return n;
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < NPR; p++) m_ready[p] = 1'b1;
    m_err = 1'b0;
  endfunction

  function automatic void model_edge();
    bit nxt [NPR];
    if (recover) begin
      for (int p = 0; p < NPR; p++) m_ready[p] = 1'b1;
      return;
    end
    for (int p = 0; p < NPR; p++) begin
      if (broadcast_hits(p) && m_ready[p] && !allocated(p)) m_err = 1'b1;
      nxt[p] = (m_ready[p] || broadcast_hits(p)) && !allocated(p);
    end
    for (int p = 0; p < NPR; p++) m_ready[p] = nxt[p];
  endfunction

  task automatic idle();
    cdb_broadcast = '0;
    for (int i = 0; i < 6; i++) cdb_tag[i] = '0;
    disp_valid0 = 1'b0; disp_valid1 = 1'b0;
    disp_dest_pr0 = '0; disp_dest_pr1 = '0;
    sa0 = '0; sb0 = '0; sa1 = '0; sb1 = '0;
    recover = 1'b0;
  endtask

  // Inputs already applied: queue this cycle's expectation, then take the edge.
  task automatic cycle();
    exp_t e;
    e.a0   = src_ready(sa0, 1'b0);
    e.b0   = src_ready(sb0, 1'b0);
    e.a1   = src_ready(sa1, 1'b1);
    e.b1   = src_ready(sb1, 1'b1);
    e.busy = 8'(waiting_regs());
    e.err  = m_err;
    exp_q.push_back(e);
    @(posedge clock);
    model_edge();
    #1;
    idle();
  endtask

  task automatic sync_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle away from the edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("src_a_rdy0", int'(src_a_rdy0), int'(e.a0));
      cmp("src_b_rdy0", int'(src_b_rdy0), int'(e.b0));
      cmp("src_a_rdy1", int'(src_a_rdy1), int'(e.a1));
      cmp("src_b_rdy1", int'(src_b_rdy1), int'(e.b1));
      cmp("busy_count", int'(busy_count), int'(e.busy));
      cmp("dup_wakeup_err", int'(dup_wakeup_err), int'(e.err));
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    model_reset();
    #1;
    cmp("reset_busy", int'(busy_count), 0);
    cmp("reset_err", int'(dup_wakeup_err), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Allocate 40, then wake it through lane 2.
    disp_valid0 = 1'b1; disp_dest_pr0 = 7'd40; cycle();
    sa0 = 7'd40; cycle();
    cmp("alloc_busy", int'(busy_count), 1);
    sa0 = 7'd40; cdb_broadcast = 6'b000100; cdb_tag[2] = 7'd40; #1;
    cmp("bypass_rdy", int'(src_a_rdy0), 1);
    cycle();
    sa0 = 7'd40; cycle();
    cmp("wake_busy", int'(busy_count), 0);

    // Set and clear of 17 in one cycle: clear wins, no error.
    cdb_broadcast = 6'b000001; cdb_tag[0] = 7'd17;
    disp_valid1 = 1'b1; disp_dest_pr1 = 7'd17; cycle();
    sa0 = 7'd17; cycle();
    cmp("collide_err", int'(dup_wakeup_err), 0);
    cdb_broadcast = 6'b000001; cdb_tag[0] = 7'd17; cycle();

    // Intra-group RAW on PR 9.
    sb1 = 7'd9; cycle();
    disp_valid0 = 1'b1; disp_dest_pr0 = 7'd9; sb1 = 7'd9; sb0 = 7'd9; #1;
    cmp("raw_mask", int'(src_b_rdy1), 0);
    cycle();
    cdb_broadcast = 6'b100000; cdb_tag[5] = 7'd9; cycle();

    // Ten PRs in flight, then recover with a lane broadcasting and a dispatch.
    for (int k = 0; k < 5; k++) begin
      disp_valid0 = 1'b1; disp_dest_pr0 = 7'(50 + 2 * k);
      disp_valid1 = 1'b1; disp_dest_pr1 = 7'(51 + 2 * k);
      cycle();
    end
    cmp("pre_recover_busy", int'(busy_count), 10);
    recover = 1'b1; cdb_broadcast = 6'b001000; cdb_tag[3] = 7'd50;
    disp_valid1 = 1'b1; disp_dest_pr1 = 7'd70; cycle();
    sa0 = 7'd70; sb0 = 7'd55; cycle();
    cmp("recover_busy", int'(busy_count), 0);

    // Double wakeup of 33 in one cycle is fine; a later stale one is not.
    disp_valid0 = 1'b1; disp_dest_pr0 = 7'd33; cycle();
    cdb_broadcast = 6'b010001; cdb_tag[0] = 7'd33; cdb_tag[4] = 7'd33; cycle();
    cmp("dual_wake_err", int'(dup_wakeup_err), 0);
    cdb_broadcast = 6'b000010; cdb_tag[1] = 7'd33; cycle();
    cycle();
    cmp("stale_err", int'(dup_wakeup_err), 1);
    cycle();

    // Asynchronous reset between edges with PR 5 busy.
    disp_valid0 = 1'b1; disp_dest_pr0 = 7'd5; cycle();
    cycle();
    sa0 = 7'd5;
    #2;
    reset = 1'b1;
    #1;
    cmp("async_busy", int'(busy_count), 0);
    cmp("async_rdy5", int'(src_a_rdy0), 1);
    cmp("async_err", int'(dup_wakeup_err), 0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle();

    // Random traffic on a narrow tag window to force collisions.
    for (int n = 0; n < 1500; n++) begin
      if (n % 300 == 299) sync_reset();
      for (int i = 0; i < 6; i++) begin
        cdb_broadcast[i] = ($urandom_range(0, 2) == 0);
        cdb_tag[i] = 7'($urandom_range(0, 23));
      end
      disp_valid0 = $urandom_range(0, 1) == 1;
      disp_valid1 = $urandom_range(0, 1) == 1;
      disp_dest_pr0 = 7'($urandom_range(0, 23));
      disp_dest_pr1 = ($urandom_range(0, 7) == 0) ? disp_dest_pr0 : 7'($urandom_range(0, 23));
      sa0 = 7'($urandom_range(0, 23));
      sb0 = 7'($urandom_range(0, 127));
      sa1 = ($urandom_range(0, 3) == 0) ? disp_dest_pr0 : 7'($urandom_range(0, 23));
      sb1 = 7'($urandom_range(0, 23));
      recover = ($urandom_range(0, 39) == 0);
      cycle();
    end

    @(negedge clock);
    #1;
    cmp("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/preg_ready_table.md
Name: preg_ready_table

Overview:
- Physical-register ready scoreboard that consumes the registered common-data-bus broadcast (6 lanes: 2 simple ALU, 2 multiplier, 2 memory).
- Dispatch allocates destination physical registers, which clears their ready bits.
- CDB broadcasts set ready bits.
- Dispatch reads source readiness, with same-cycle CDB bypass and intra-group dependency masking, to initialise reservation-station operand-ready flags.

Parameters:
- NUM_PR, 128, number of physical registers
- PR_W, 7, physical register tag width
- NUM_CDB, 6, broadcast lanes
- CNT_W, 8, width of busy counter (holds 0..NUM_PR)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cdb_broadcast  in  6  per-lane valid from the CDB register stage; bit i qualifies cdb_pr_tag<i>
- cdb_pr_tag0..cdb_pr_tag5  in  7 each  completing physical register tags
- disp_valid0, disp_valid1  in  1 each  dispatch slot valid; slot0 is older
- disp_dest_pr0, disp_dest_pr1  in  7 each  newly allocated destination PR
- disp_src_a_pr0, disp_src_b_pr0, disp_src_a_pr1, disp_src_b_pr1  in  7 each  source PR tags
- recover  in  1  pipeline flush (branch mispredict or exception at retire)
- src_a_rdy0, src_b_rdy0, src_a_rdy1, src_b_rdy1  out  1 each  source ready, combinational
- busy_count  out  8  registered count of not-ready PRs
- dup_wakeup_err  out  1  sticky debug flag

Behaviour:
- State: ready[NUM_PR-1:0], busy_count, dup_wakeup_err.
- Reset (async, active-high): ready = all ones; busy_count = 0; dup_wakeup_err = 0. Outputs reflect the reset state immediately, without waiting for a clock edge.
- Set vector: S[p] = OR over i of (cdb_broadcast[i] && cdb_pr_tag<i> == p). Duplicate tags on multiple lanes are legal and equivalent to a single set.
- Clear vector: C[p] = (disp_valid0 && disp_dest_pr0 == p) || (disp_valid1 && disp_dest_pr1 == p).
- Next state at posedge:
  - recover = 1: ready = all ones. Overrides S and C in the same cycle. All in-flight producers are squashed and committed state is ready.
  - Otherwise: ready_next = (ready | S) & ~C. Clear wins over set on the same PR, because the newer allocation dominates.
- busy_count is registered and equals popcount(~ready_next). It is updated on the same edge as ready, so it reads 0 the cycle after recover.
- Source lookup (combinational, no clock):
  - Base: rdy = ready[src] | S[src].
  - The CDB bypass makes a tag broadcast this cycle visible to dispatch this cycle.
  - Slot1 sources: additionally forced to 0 if disp_valid0 && src == disp_dest_pr0 (intra-group RAW).
  - Slot0 sources are not masked by slot1's destination.
  - Lookups ignore recover; the dispatch stage is squashed by recover upstream.
- dup_wakeup_err:
  - Set at posedge when recover = 0 and any valid lane targets p with ready[p] = 1 and C[p] = 0.
  - Sticky; cleared only by reset.
- Dispatch with disp_valid0 = disp_valid1 = 1 and equal dest PRs: clear applied once; busy_count increments by 1. The free list guarantees this never occurs; the behaviour is still defined.
- Latency: a CDB set is visible in ready[] one cycle after broadcast, and visible combinationally via bypass in the same cycle.

Decomposition:
- Shared package/header: PR_W, NUM_PR, NUM_CDB, CNT_W constants. Same `SD delay macro for nonblocking assignments.
- One natural sub-module: pr_decode (7-bit tag + valid -> 128-bit one-hot), instantiated 8 times (6 CDB lanes, 2 dispatch dests).
- The popcount for busy_count stays inline.

Test Plan:
- Reset mid-operation: ready[5] = 0 and busy_count = 1, then assert reset asynchronously between edges -> busy_count = 0, and src_a_rdy0 = 1 for tag 5 without waiting for a clock edge.
- Allocate/wakeup:
  - Cycle 0: disp_valid0 = 1, disp_dest_pr0 = 40. Cycle 1: src_a_pr0 = 40 -> src_a_rdy0 = 0, busy_count = 1.
  - Cycle 2: cdb_broadcast = 6'b000100, tag2 = 40 -> src_a_rdy0 = 1 the same cycle via bypass. Cycle 3: busy_count = 0.
- Clear-vs-set collision: cdb lane 0 tag 17 and disp_dest_pr1 = 17 in the same cycle -> ready[17] = 0 next cycle; busy_count +1; dup_wakeup_err stays 0.
- Intra-group RAW: disp_dest_pr0 = 9 (ready), disp_src_b_pr1 = 9 -> src_b_rdy1 = 0. With disp_valid0 = 0 -> src_b_rdy1 = 1.
- Recover: 10 PRs not ready and lane 3 broadcasting, then recover = 1 with disp_valid1 = 1, dest 70 -> next cycle all ready and busy_count = 0 (PR 70 ready).
- Duplicate and stale wakeup:
  - Lanes 0 and 4 both tag 33 (not ready) -> ready[33] = 1; busy_count drops by 1; no error.
  - Later lane 1 tag 33 again -> dup_wakeup_err = 1 and stays 1 until reset.
